// File: rtl/gain_stereo_scheduler.sv
// Stereo gain scheduler: one shared multiply/dequantize/shift datapath serves the left
// and right channels round-robin, and ramps the applied volume once per completed stereo pair.
module gain_stereo_scheduler #(
  parameter int          BITS      = 10,
  parameter int          OUT_SHIFT = 4,
  parameter logic [15:0] VOL_INIT  = 16'd1024,
  parameter logic [15:0] RAMP_STEP = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        l_rd_en,
  input  logic        l_empty,
  input  logic [31:0] l_dout,
  output logic        r_rd_en,
  input  logic        r_empty,
  input  logic [31:0] r_dout,
  output logic        l_wr_en,
  input  logic        l_full,
  output logic [31:0] l_din,
  output logic        r_wr_en,
  input  logic        r_full,
  output logic [31:0] r_din,
  input  logic        vol_wr_en,
  input  logic [15:0] vol_din,
  input  logic        mute,
  output logic [15:0] cur_vol
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1} state_t;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_t;

  localparam logic signed [63:0] TRUNC_BIAS = (64'sd1 <<< BITS) - 64'sd1;

  state_t      state, next_state;
  ch_t         last_served, grant;
  logic [31:0] result;
  logic        pair_flag;
  logic [15:0] target;

  logic               grant_l, grant_r, pop, ramp_event;
  logic signed [31:0] sample;
  logic signed [63:0] product, dequant;
  logic [31:0]        gained;
  logic [15:0]        eff_target, vol_diff, vol_step, ramped_vol;

  // Both eligible: the channel not served last wins; otherwise whichever is ready.
  assign grant_r = !r_empty && (l_empty || last_served == CH_LEFT);
  assign grant_l = !l_empty && !grant_r;

  always_comb begin
    sample  = grant_r ? $signed(r_dout) : $signed(l_dout);
    product = $signed({{32{sample[31]}}, sample}) * $signed({48'd0, cur_vol});
    // Bias negative products so the shift truncates toward zero, not toward -inf.
    dequant = product[63] ? ((product + TRUNC_BIAS) >>> BITS) : (product >>> BITS);
    gained  = 32'(dequant <<< OUT_SHIFT);
  end

  always_comb begin
    eff_target = mute ? 16'd0 : target;
    vol_diff   = (cur_vol < eff_target) ? (eff_target - cur_vol) : (cur_vol - eff_target);
    vol_step   = (vol_diff > RAMP_STEP) ? RAMP_STEP : vol_diff;
    ramped_vol = (cur_vol < eff_target) ? (cur_vol + vol_step) : (cur_vol - vol_step);
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    l_rd_en    = 1'b0;
    r_rd_en    = 1'b0;
    l_wr_en    = 1'b0;
    r_wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_l || grant_r) begin
          pop        = 1'b1;
          l_rd_en    = grant_l;
          r_rd_en    = grant_r;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (grant == CH_RIGHT ? !r_full : !l_full) begin
          l_wr_en    = (grant == CH_LEFT);
          r_wr_en    = (grant == CH_RIGHT);
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign l_din      = l_wr_en ? result : 32'd0;
  assign r_din      = r_wr_en ? result : 32'd0;
  assign ramp_event = r_wr_en && pair_flag;

  // NOTE: sequential state uses non-blocking assignments so every register sees the
  // pre-edge values; this is what lets a coincident vol_wr_en leave the ramp on the old target.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= CH_RIGHT;
      grant       <= CH_LEFT;
      result      <= 32'd0;
      pair_flag   <= 1'b0;
      cur_vol     <= VOL_INIT;
      target      <= VOL_INIT;
    end else begin
      state <= next_state;
      if (pop) begin
        result <= gained;
        grant  <= grant_r ? CH_RIGHT : CH_LEFT;
      end
      if (l_wr_en) begin
        last_served <= CH_LEFT;
        pair_flag   <= 1'b1;
      end
      if (r_wr_en) begin
        last_served <= CH_RIGHT;
        pair_flag   <= 1'b0;
      end
      if (ramp_event) cur_vol <= ramped_vol;
      if (vol_wr_en)  target  <= vol_din;
    end
  end

endmodule

// File: tb/tb_gain_stereo_scheduler.sv
// Directed bench for gain_stereo_scheduler: models the four FIFOs with queues and checks
// gain arithmetic, arbitration order, backpressure, volume/mute ramp and asynchronous reset.
module tb_gain_stereo_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        l_rd_en, r_rd_en, l_wr_en, r_wr_en;
  logic        l_empty = 1'b1, r_empty = 1'b1;
  logic [31:0] l_dout = '0, r_dout = '0;
  logic        l_full = 1'b0, r_full = 1'b0;
  logic [31:0] l_din, r_din;
  logic        vol_wr_en = 1'b0;
  logic [15:0] vol_din = '0;
  logic        mute = 1'b0;
  logic [15:0] cur_vol;

  gain_stereo_scheduler dut (
    .clock(clock), .reset(reset),
    .l_rd_en(l_rd_en), .l_empty(l_empty), .l_dout(l_dout),
    .r_rd_en(r_rd_en), .r_empty(r_empty), .r_dout(r_dout),
    .l_wr_en(l_wr_en), .l_full(l_full), .l_din(l_din),
    .r_wr_en(r_wr_en), .r_full(r_full), .r_din(r_din),
    .vol_wr_en(vol_wr_en), .vol_din(vol_din), .mute(mute), .cur_vol(cur_vol)
  );

  always #5 clock = ~clock;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  lq[$], rq[$];
  int  lout[$], rout[$], lw_cyc[$], rw_cyc[$];
  byte pop_ch[$];
  int  pop_cyc[$];
  bit  pop_l = 0, pop_r = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic void refresh();
    l_empty = (lq.size() == 0);
    r_empty = (rq.size() == 0);
    l_dout  = l_empty ? 32'd0 : 32'(lq[0]);
    r_dout  = r_empty ? 32'd0 : 32'(rq[0]);
  endfunction

  // Strobes are sampled mid-cycle; the input FIFOs advance just after the edge.
  always @(negedge clock) begin
    pop_l = l_rd_en;
    pop_r = r_rd_en;
    if (l_rd_en) begin pop_ch.push_back("L"); pop_cyc.push_back(cyc); end
    if (r_rd_en) begin pop_ch.push_back("R"); pop_cyc.push_back(cyc); end
    if (l_wr_en) begin lout.push_back(int'($signed(l_din))); lw_cyc.push_back(cyc); end
    if (r_wr_en) begin rout.push_back(int'($signed(r_din))); rw_cyc.push_back(cyc); end
  end

  always @(posedge clock) begin
    cyc++;
    #1;
    if (pop_l && lq.size() > 0) void'(lq.pop_front());
    if (pop_r && rq.size() > 0) void'(rq.pop_front());
    pop_l = 0;
    pop_r = 0;
    refresh();
  end

  task automatic sync();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_log();
    pop_ch.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_outs(input int nl, input int nr);
    for (int i = 0; i < 3000 && !(lout.size() >= nl && rout.size() >= nr); i++)
      @(posedge clock);
    #2;
    check("wait_l_count", lout.size(), nl);
    check("wait_r_count", rout.size(), nr);
  endtask

  task automatic wait_pop();
    for (int i = 0; i < 200 && pop_ch.size() == 0; i++) @(posedge clock);
    check("pop_seen", pop_ch.size(), 1);
  endtask

  task automatic run_pairs(input int n);
    int bl, br;
    bl = lout.size();
    br = rout.size();
    sync();
    for (int i = 0; i < n; i++) begin lq.push_back(0); rq.push_back(0); end
    refresh();
    wait_outs(bl + n, br + n);
    sync();
  endtask

  task automatic set_vol(input logic [15:0] v);
    sync();
    vol_wr_en = 1'b1;
    vol_din   = v;
    sync();
    vol_wr_en = 1'b0;
  endtask

  initial begin
    int nl, nr;
    // Reset state
    #12;
    check("rst_cur_vol", cur_vol, 16'd1024);
    check("rst_strobes", {l_rd_en, r_rd_en, l_wr_en, r_wr_en}, 4'b0000);
    check("rst_l_din", l_din, 32'd0);
    check("rst_r_din", r_din, 32'd0);
    sync();
    reset = 1'b0;

    // Unity gain and one-cycle pop-to-push latency
    clear_log();
    sync();
    lq.push_back(100);
    refresh();
    wait_outs(1, 0);
    check("unity_left", lout[0], 1600);
    check("unity_latency", lw_cyc[0] - pop_cyc[0], 1);
    sync();
    rq.push_back(-7);
    refresh();
    wait_outs(1, 1);
    check("unity_right", rout[0], -112);
    check("unity_vol", cur_vol, 16'd1024);

    // Round-robin with both FIFOs loaded
    clear_log();
    sync();
    for (int i = 1; i <= 4; i++) begin lq.push_back(i); rq.push_back(-i); end
    refresh();
    wait_outs(5, 5);
    for (int i = 0; i < 8; i++) check("arb_order", pop_ch[i], (i % 2) ? "R" : "L");
    for (int i = 0; i < 7; i++) check("arb_spacing", pop_cyc[i+1] - pop_cyc[i], 2);
    for (int i = 1; i <= 4; i++) begin
      check("arb_l_val", lout[i], 16 * i);
      check("arb_r_val", rout[i], -16 * i);
    end

    // Right-only stream runs back to back
    clear_log();
    sync();
    rq.push_back(10); rq.push_back(20); rq.push_back(30);
    refresh();
    wait_outs(5, 8);
    for (int i = 0; i < 3; i++) check("ronly_ch", pop_ch[i], "R");
    for (int i = 0; i < 2; i++) check("ronly_spacing", pop_cyc[i+1] - pop_cyc[i], 2);
    check("ronly_val", rout[7], 480);

    // Backpressure on the left output holds result and blocks the right channel
    clear_log();
    sync();
    l_full = 1'b1;
    lq.push_back(5);
    rq.push_back(6);
    refresh();
    wait_pop();
    check("bp_first_l", pop_ch[0], "L");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_l_wr_held", l_wr_en, 1'b0);
      check("bp_no_r_rd", r_rd_en, 1'b0);
    end
    sync();
    l_full = 1'b0;
    @(negedge clock);
    check("bp_l_wr_release", l_wr_en, 1'b1);
    check("bp_l_din", l_din, 32'd80);
    wait_outs(6, 9);
    check("bp_r_val", rout[8], 96);

    // Volume ramp 1024 -> 1000
    set_vol(16'd1000);
    check("ramp_no_event", cur_vol, 16'd1024);
    run_pairs(1); check("ramp_1", cur_vol, 16'd1008);
    run_pairs(1); check("ramp_2", cur_vol, 16'd1000);
    run_pairs(1); check("ramp_stable", cur_vol, 16'd1000);

    // Mute ramps to zero, release ramps back up
    sync();
    mute = 1'b1;
    run_pairs(1);  check("mute_1", cur_vol, 16'd984);
    run_pairs(61); check("mute_62", cur_vol, 16'd8);
    run_pairs(1);  check("mute_zero", cur_vol, 16'd0);
    run_pairs(1);  check("mute_hold", cur_vol, 16'd0);
    sync();
    mute = 1'b0;
    run_pairs(1);  check("unmute_1", cur_vol, 16'd16);
    run_pairs(62); check("unmute_done", cur_vol, 16'd1000);
    run_pairs(1);  check("unmute_stable", cur_vol, 16'd1000);

    // Volume 341: truncation toward zero
    set_vol(16'd341);
    run_pairs(42);
    check("vol_341", cur_vol, 16'd341);
    nl = lout.size();
    nr = rout.size();
    sync();
    lq.push_back(-3); lq.push_back(3); lq.push_back(4);
    rq.push_back(-4);
    refresh();
    wait_outs(nl + 3, nr + 1);
    check("trunc_neg3", lout[nl], 0);
    check("trunc_pos3", lout[nl+1], 0);
    check("trunc_pos4", lout[nl+2], 16);
    check("trunc_neg4", rout[nr], -16);

    // Reset while a right result is held in WRITE
    sync();
    lq.push_back(7);
    refresh();
    wait_outs(nl + 4, nr + 1);
    clear_log();
    sync();
    r_full = 1'b1;
    rq.push_back(9);
    refresh();
    wait_pop();
    check("rst_pre_ch", pop_ch[0], "R");
    @(negedge clock);
    check("rst_pre_r_wr", r_wr_en, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_strobes", {l_rd_en, r_rd_en, l_wr_en, r_wr_en}, 4'b0000);
    check("rst_mid_r_din", r_din, 32'd0);
    check("rst_mid_vol", cur_vol, 16'd1024);
    sync();
    reset  = 1'b0;
    r_full = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    check("rst_no_write", rout.size(), nr + 1);
    clear_log();
    sync();
    lq.push_back(10);
    rq.push_back(11);
    refresh();
    wait_outs(nl + 5, nr + 2);
    check("rst_first_left", pop_ch[0], "L");
    check("rst_l_val", lout[nl+4], 160);
    check("rst_r_val", rout[nr+1], 176);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
